tx_framer_8b10: RTL and testbench



---
 rtl/v8b10b_pkg.sv | 25 ++
 rtl/crc8_byte.sv | 23 ++
 rtl/tx_framer_8b10.sv | 164 ++++++++++++++++
 tb/tb_tx_framer_8b10.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v8b10b_pkg.sv
// Shared symbol constants, FSM state encoding and CRC polynomial for the 8b/10b transmit path.
// Optional macro V8B10B_TX_CRC_EN adds the CRC trailer state.
package v8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // idle comma
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] K28_0 = 8'h1C;  // underrun pad
    localparam logic [7:0] K30_7 = 8'hFE;  // frame error

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOF   = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOF   = 3'd3,
        ST_ABORT = 3'd4
`ifdef V8B10B_TX_CRC_EN
        ,
        ST_CRC   = 3'd5
`endif
    } tx_state_t;

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 update over one byte, MSB first, no reflection.
module crc8_byte
    import v8b10b_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    always_comb begin
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/tx_framer_8b10.sv
// Transmit framer feeding encoder_8b10: SOF/data/EOF framing, comma idles, inter-frame gap, pad/abort.
// Optional macro V8B10B_TX_CRC_EN inserts a CRC-8 symbol between the last byte and EOF.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | emit K28.5, count inter-frame gap, wait for s_valid
// ST_SOF   | emit K27.7, open frame
// ST_DATA  | emit accepted byte, or K28.0 pad on underrun
// ST_CRC   | emit running CRC-8 as data (CRC build only)
// ST_EOF   | emit K29.7, restart gap count
// ST_ABORT | emit K30.7, pulse abort, restart gap count
module tx_framer_8b10
    import v8b10b_pkg::*;
#(
    parameter int IFG_MIN = 2,
    parameter int MAX_PAD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       enc_en,
    output logic       enc_kin,
    output logic [7:0] enc_din,
    output logic       abort
);

    localparam logic [7:0] IFG_LIM = 8'(IFG_MIN);
    localparam logic [8:0] IFG_THR = 9'(IFG_MIN);
    localparam logic [8:0] PAD_LIM = 9'(MAX_PAD);

    tx_state_t  state, state_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    logic [7:0] pad_cnt, pad_nxt;
    logic       sym_kin;
    logic [7:0] sym_din;
    logic       abort_nxt;

`ifdef V8B10B_TX_CRC_EN
    logic [7:0] crc_q, crc_nxt, crc_upd;

    crc8_byte u_crc8 (
        .crc      (crc_q),
        .data     (s_data),
        .crc_next (crc_upd)
    );
`endif

    assign s_ready = (state == ST_DATA) && ce;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pad_nxt   = pad_cnt;
        sym_kin   = 1'b1;
        sym_din   = K28_5;
        abort_nxt = 1'b0;
`ifdef V8B10B_TX_CRC_EN
        crc_nxt   = crc_q;
`endif
        case (state)
            ST_IDLE: begin
                if (gap_cnt < IFG_LIM) begin
                    gap_nxt = gap_cnt + 8'd1;
                end
                // The idle emitted on this symbol already counts toward the gap.
                if ((({1'b0, gap_cnt} + 9'd1) >= IFG_THR) && s_valid) begin
                    state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                sym_din   = K27_7;
                pad_nxt   = 8'd0;
`ifdef V8B10B_TX_CRC_EN
                crc_nxt   = 8'd0;
`endif
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (s_valid) begin
                    sym_kin = 1'b0;
                    sym_din = s_data;
                    pad_nxt = 8'd0;
`ifdef V8B10B_TX_CRC_EN
                    crc_nxt = crc_upd;
                    if (s_last) begin
                        state_nxt = ST_CRC;
                    end
`else
                    if (s_last) begin
                        state_nxt = ST_EOF;
                    end
`endif
                end else begin
                    sym_din = K28_0;
                    pad_nxt = pad_cnt + 8'd1;
                    if (({1'b0, pad_cnt} + 9'd1) >= PAD_LIM) begin
                        state_nxt = ST_ABORT;
                    end
                end
            end
`ifdef V8B10B_TX_CRC_EN
            ST_CRC: begin
                sym_kin   = 1'b0;
                sym_din   = crc_q;
                state_nxt = ST_EOF;
            end
`endif
            ST_EOF: begin
                sym_din   = K29_7;
                gap_nxt   = 8'd0;
                state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                sym_din   = K30_7;
                abort_nxt = 1'b1;
                gap_nxt   = 8'd0;
                pad_nxt   = 8'd0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gap_cnt <= IFG_LIM;
            pad_cnt <= 8'd0;
            enc_en  <= 1'b0;
            enc_kin <= 1'b1;
            enc_din <= K28_5;
            abort   <= 1'b0;
        end else begin
            enc_en <= ce;
            if (ce) begin
                state   <= state_nxt;
                gap_cnt <= gap_nxt;
                pad_cnt <= pad_nxt;
                enc_kin <= sym_kin;
                enc_din <= sym_din;
                abort   <= abort_nxt;
            end else begin
                abort   <= 1'b0;
            end
        end
    end

`ifdef V8B10B_TX_CRC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'd0;
        end else if (ce) begin
            crc_q <= crc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_tx_framer_8b10.sv
// Randomized scoreboard bench for tx_framer_8b10; expected symbols come from a packet-level model.
module tb_tx_framer_8b10;

    localparam int IFG_MIN = 2;
    localparam int MAX_PAD = 8;
    localparam logic [8:0] S_IDLE = {1'b1, 8'hBC};
    localparam logic [8:0] S_SOF  = {1'b1, 8'hFB};
    localparam logic [8:0] S_EOF  = {1'b1, 8'hFD};
    localparam logic [8:0] S_PAD  = {1'b1, 8'h1C};
    localparam logic [8:0] S_ERR  = {1'b1, 8'hFE};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, enc_en, enc_kin, abort;
    logic [7:0] enc_din;

    int n_checks = 0;
    int n_fail = 0;
    int ce_mode = 0;
    int cyc = 0;
    logic [8:0] sb[$];
    logic [7:0] pkt[$];

    tx_framer_8b10 #(.IFG_MIN(IFG_MIN), .MAX_PAD(MAX_PAD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .enc_en  (enc_en),
        .enc_kin (enc_kin),
        .enc_din (enc_din),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [8:0] r;
        r = {1'b0, c ^ b};
        for (int k = 0; k < 8; k++) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic gen_ce();
        case (ce_mode)
            0: return 1'b1;
            1: return (cyc % 3) == 0;
            default: return $urandom_range(0, 2) != 0;
        endcase
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        output logic hs, output logic ce_o);
        @(negedge clk);
        cyc++;
        ce = gen_ce();
        s_valid = v;
        s_data = d;
        s_last = l;
        #1;
        if (!ce) chk("s_ready_ce0", s_ready, 0);
        hs = s_valid && s_ready;
        ce_o = ce;
    endtask

    task automatic idle_steps(input int n);
        logic hs, c;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, hs, c);
    endtask

    // Stall of stall_len counted symbols is inserted just before byte stall_at (stall_at >= 1).
    task automatic send_pkt(input int stall_at, input int stall_len);
        logic hs, c;
        logic [7:0] crc;
        int n, waited;
        crc = 8'h00;
        sb.push_back(S_SOF);
        for (int i = 0; i < pkt.size(); i++) begin
            if (i == stall_at && i > 0) begin
                n = 0;
                while (n < stall_len) begin
                    step(1'b0, 8'h00, 1'b0, hs, c);
                    if (c) begin
                        n++;
                        sb.push_back(S_PAD);
                        if (n == MAX_PAD) begin
                            sb.push_back(S_ERR);
                            return;
                        end
                    end
                end
            end
            waited = 0;
            hs = 1'b0;
            while (!hs) begin
                step(1'b1, pkt[i], i == pkt.size() - 1, hs, c);
                waited++;
                if (!hs && waited > 200) begin
                    chk("handshake_timeout", 0, 1);
                    return;
                end
            end
            sb.push_back({1'b0, pkt[i]});
            crc = crc8(crc, pkt[i]);
        end
`ifdef V8B10B_TX_CRC_EN
        sb.push_back({1'b0, crc});
`endif
        sb.push_back(S_EOF);
    endtask

    initial begin : monitor
        logic ce_s, v_s;
        logic [8:0] sym, prev, exp;
        int idle_cnt;
        bit in_frame, seen_end, loose;
        prev = S_IDLE;
        idle_cnt = 0;
        in_frame = 0;
        seen_end = 0;
        loose = 0;
        forever begin
            @(posedge clk);
            ce_s = ce;
            v_s = s_valid;
            @(negedge clk);
            if (!rst_n) begin
                prev = S_IDLE;
                idle_cnt = 0;
                in_frame = 0;
                seen_end = 0;
                loose = 0;
            end else begin
                sym = {enc_kin, enc_din};
                chk("enc_en_vs_ce", enc_en, ce_s);
                if (enc_en) begin
                    chk("abort_with_err", abort, sym == S_ERR);
                    if (!in_frame && sym == S_IDLE) begin
                        idle_cnt++;
                        if (!v_s) loose = 1;
                    end else if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_symbol: got %0h expected nothing queued", sym);
                    end else begin
                        exp = sb.pop_front();
                        chk("symbol", sym, exp);
                        if (exp == S_SOF) begin
                            in_frame = 1;
                            if (seen_end) begin
                                if (loose) chk("ifg_min", idle_cnt >= IFG_MIN, 1);
                                else chk("ifg_exact", idle_cnt, IFG_MIN);
                            end
                        end else if (exp == S_EOF || exp == S_ERR) begin
                            in_frame = 0;
                            seen_end = 1;
                            idle_cnt = 0;
                            loose = 0;
                        end
                    end
                end else begin
                    chk("hold_sym", sym, prev);
                    chk("abort_no_ce", abort, 0);
                end
                prev = sym;
            end
        end
    end

    initial begin : driver
        logic hs, c;
        int len, sa, sl;

        #12;
        chk("rst_enc_en", enc_en, 0);
        chk("rst_enc_kin", enc_kin, 1);
        chk("rst_enc_din", enc_din, 8'hBC);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_abort", abort, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // idle stream after reset
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, hs, c);
            chk("idle_s_ready", s_ready, 0);
        end

        ce_mode = 0;
        pkt = '{8'h11, 8'h22, 8'h33};
        send_pkt(-1, 0);
        pkt = '{8'h44, 8'h55};
        send_pkt(-1, 0);
        idle_steps(4);

        ce_mode = 1;
        pkt = '{8'h11, 8'h22, 8'h33};
        send_pkt(-1, 0);
        idle_steps(9);

        ce_mode = 0;
        pkt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_pkt(2, 3);
        pkt = '{8'h5A};
        send_pkt(-1, 0);
        pkt = '{8'hB1, 8'hB2, 8'hB3};
        send_pkt(1, 8);
        pkt = '{8'h77, 8'h88};
        send_pkt(-1, 0);
        idle_steps(5);

`ifdef V8B10B_TX_CRC_EN
        pkt = '{8'h01};
        send_pkt(-1, 0);
        idle_steps(5);
`endif

        for (int p = 0; p < 14; p++) begin
            ce_mode = $urandom_range(0, 2);
            len = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
            sa = -1;
            sl = 0;
            if (len > 1 && $urandom_range(0, 2) == 0) begin
                sa = $urandom_range(1, len - 1);
                sl = $urandom_range(1, 10);
            end
            send_pkt(sa, sl);
            idle_steps($urandom_range(0, 4));
        end

        // reset in the middle of a frame
        ce_mode = 0;
        pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        sb.push_back(S_SOF);
        hs = 1'b0;
        for (int i = 0; i < 40 && !hs; i++) step(1'b1, 8'hC1, 1'b0, hs, c);
        chk("mid_first_hs", hs, 1);
        sb.push_back({1'b0, 8'hC1});
        step(1'b1, 8'hC2, 1'b0, hs, c);
        chk("mid_second_hs", hs, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        ce = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_enc_en", enc_en, 0);
        chk("mid_rst_enc_kin", enc_kin, 1);
        chk("mid_rst_enc_din", enc_din, 8'hBC);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_abort", abort, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        pkt = '{8'hD1, 8'hD2};
        send_pkt(-1, 0);

        idle_steps(60);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
